// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Shares one physical-memory port between the I-cache and D-cache miss paths.
//   D-side has priority; optional starvation guard via ARB_STARVE_GUARD_EN.
//   Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic                  grant_i;
    logic                  grant_d;
    logic                  starve_hit;
    logic                  serving;

`ifdef ARB_STARVE_GUARD_EN
    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == CNT_MAX);

    // Counts D grants that bypassed a waiting I request; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d) begin
            if (!i_read) begin
                starve_d = '0;
            end else if (starve_q != CNT_MAX) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        grant_i = 1'b0;
        grant_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_read && starve_hit) begin
                    grant_i = 1'b1;
                end else if (d_read || d_write) begin
                    grant_d = 1'b1;
                end else if (i_read) begin
                    grant_i = 1'b1;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (pmem_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A simultaneous read+write from D resolves to a write.
        if (grant_d) begin
            state_d = ST_SERVE_D;
            addr_d  = d_address;
            wr_d    = d_write;
            rd_d    = ~d_write;
            wdata_d = d_wdata;
        end else if (grant_i) begin
            state_d = ST_SERVE_I;
            addr_d  = i_address;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign serving      = (state_q != ST_IDLE);
    assign pmem_read    = rd_q & serving;
    assign pmem_write   = wr_q & serving;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses only exist while the owner is being served; stray pmem_resp is dropped.
    assign i_resp  = pmem_resp & (state_q == ST_SERVE_I);
    assign d_resp  = pmem_resp & (state_q == ST_SERVE_D);
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
`default_nettype wire
